// File: rtl/regfile_defs.sv
// Shared defaults and output-buffer state encoding for the register-file read port.
package regfile_defs;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_REGS_DEF   = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/regfile_read_mux.sv
// One read port: zero register, out-of-range squash, write bypass, storage slice.
module regfile_read_mux
    import regfile_defs::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           wr_enable,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_bus,
    output logic [DATA_WIDTH-1:0]          data
);

    logic                  in_range;
    logic [DATA_WIDTH-1:0] slice;

    // Index 0 is never matched, so register zero reads as 0 like any
    // out-of-range index.
    always_comb begin
        in_range = 1'b0;
        slice    = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                in_range = 1'b1;
                slice    = reg_bus[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        data = '0;
        if (in_range) begin
            data = (wr_enable && (wr_addr == addr)) ? wr_data : slice;
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Two-port register read with write bypass and a two-deep coherent
// output buffer (output register plus skid entry).
module regfile_read_port
    import regfile_defs::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr_a,
    input  logic [ADDR_WIDTH-1:0]          req_addr_b,
    input  logic                           wr_enable,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_bus,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_WIDTH-1:0]          rsp_data_a,
    output logic [DATA_WIDTH-1:0]          rsp_data_b
);

    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

    buf_state_t state;

    logic [DATA_WIDTH-1:0] new_a;
    logic [DATA_WIDTH-1:0] new_b;
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;
    logic [DATA_WIDTH-1:0] skid_a;
    logic [DATA_WIDTH-1:0] skid_b;
    logic [ADDR_WIDTH-1:0] out_addr_a;
    logic [ADDR_WIDTH-1:0] out_addr_b;
    logic [ADDR_WIDTH-1:0] skid_addr_a;
    logic [ADDR_WIDTH-1:0] skid_addr_b;

    logic [DATA_WIDTH-1:0] out_a_c;
    logic [DATA_WIDTH-1:0] out_b_c;
    logic [DATA_WIDTH-1:0] skid_a_c;
    logic [DATA_WIDTH-1:0] skid_b_c;

    logic accept;
    logic drain;

    regfile_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mux_a (
        .addr      (req_addr_a),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_bus   (reg_bus),
        .data      (new_a)
    );

    regfile_read_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mux_b (
        .addr      (req_addr_b),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_bus   (reg_bus),
        .data      (new_b)
    );

    assign req_ready  = reset && (state != ST_TWO);
    assign rsp_valid  = (state != ST_EMPTY);
    assign accept     = req_valid && req_ready;
    assign drain      = rsp_valid && rsp_ready;
    assign rsp_data_a = out_a;
    assign rsp_data_b = out_b;

    // Held values track writes to their register so a stalled response
    // never goes stale; register zero and out-of-range slots stay 0.
    function automatic logic [DATA_WIDTH-1:0] fresh(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] d
    );
        logic hit;
        hit = wr_enable && (wr_addr == a) && (a != '0)
              && ({1'b0, a} < REG_LIMIT);
        return hit ? wr_data : d;
    endfunction

    assign out_a_c  = fresh(out_addr_a, out_a);
    assign out_b_c  = fresh(out_addr_b, out_b);
    assign skid_a_c = fresh(skid_addr_a, skid_a);
    assign skid_b_c = fresh(skid_addr_b, skid_b);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_EMPTY;
            out_a       <= '0;
            out_b       <= '0;
            skid_a      <= '0;
            skid_b      <= '0;
            out_addr_a  <= '0;
            out_addr_b  <= '0;
            skid_addr_a <= '0;
            skid_addr_b <= '0;
        end else begin
            out_a  <= out_a_c;
            out_b  <= out_b_c;
            skid_a <= skid_a_c;
            skid_b <= skid_b_c;
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_a      <= new_a;
                        out_b      <= new_b;
                        out_addr_a <= req_addr_a;
                        out_addr_b <= req_addr_b;
                        state      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        skid_a      <= new_a;
                        skid_b      <= new_b;
                        skid_addr_a <= req_addr_a;
                        skid_addr_b <= req_addr_b;
                        state       <= ST_TWO;
                    end else if (accept) begin
                        out_a      <= new_a;
                        out_b      <= new_b;
                        out_addr_a <= req_addr_a;
                        out_addr_b <= req_addr_b;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        out_a      <= skid_a_c;
                        out_b      <= skid_b_c;
                        out_addr_a <= skid_addr_a;
                        out_addr_b <= skid_addr_b;
                        state      <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register data width in bits.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers.
REQ-003 Parameter ADDR_WIDTH, default 5: register address width in bits.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  read request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_addr_a  input  ADDR_WIDTH  port A register index.
REQ-009 req_addr_b  input  ADDR_WIDTH  port B register index.
REQ-010 wr_enable  input  1  storage array is being written this cycle.
REQ-011 wr_addr  input  ADDR_WIDTH  index being written.
REQ-012 wr_data  input  DATA_WIDTH  value being written.
REQ-013 reg_bus  input  NUM_REGS*DATA_WIDTH  flattened storage contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 rsp_valid  output  1  response held on rsp_data_a/b.
REQ-015 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-016 rsp_data_a  output  DATA_WIDTH  port A read data.
REQ-017 rsp_data_b  output  DATA_WIDTH  port B read data.

Function
REQ-018 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; a response SHALL be accepted on a rising edge with rsp_valid=1 and rsp_ready=1.
REQ-019 Read value per port at acceptance: 0 if addr=0; else wr_data if wr_enable=1, wr_addr=addr and wr_addr!=0 (write bypass); else the reg_bus slice for addr.
REQ-020 Latency: an accepted request SHALL appear on rsp_valid/rsp_data in the next cycle when the output stage is empty or being drained the same cycle.
REQ-021 Buffering: one output register plus one skid entry; states EMPTY, ONE (output valid), TWO (output and skid valid).
REQ-022 Transitions: EMPTY+accept->ONE; ONE+accept without drain->TWO; ONE+drain without accept->EMPTY; ONE+accept+drain->ONE (new data to output); TWO+drain->ONE (skid moves to output); otherwise hold.
REQ-023 req_ready SHALL be 1 exactly when state is not TWO and reset is deasserted; rsp_valid SHALL be 1 exactly in ONE or TWO.
REQ-024 Coherence: every held port value (output and skid) whose stored address matches a write with wr_enable=1 and wr_addr!=0 SHALL be replaced by wr_data at that edge.
REQ-025 Writes to address 0 SHALL never alter any response; reads of address 0 SHALL always return 0.
REQ-026 rsp_data_a/b SHALL stay stable while rsp_valid=1 and rsp_ready=0, except for REQ-024 updates.
REQ-027 Out-of-range addresses (>= NUM_REGS) SHALL return 0.
REQ-028 Ordering: responses SHALL be delivered in acceptance order; no request dropped or duplicated.

Reset
REQ-029 While reset=0: state EMPTY, rsp_valid=0, req_ready=0, rsp_data_a=rsp_data_b=0, skid data and stored addresses 0.
REQ-030 Reset asserted mid-transaction SHALL discard all held responses immediately (asynchronously); req_ready SHALL be 1 in the first cycle after release.

Structure
REQ-031 DATA_WIDTH, NUM_REGS, ADDR_WIDTH defaults and the EMPTY/ONE/TWO state encodings SHALL live in shared header regfile_defs.
REQ-032 Per-port selection (zero check, bypass, reg_bus slice mux) SHALL be sub-module regfile_read_mux, instantiated once per port.

Verification
REQ-033 reg_bus r5=0x0000_00A5, request a=5,b=0, rsp_ready=1 -> next cycle rsp_valid=1, a=0x0000_00A5, b=0.
REQ-034 Request a=7 with same-cycle wr_enable=1, wr_addr=7, wr_data=0xDEAD_BEEF, reg_bus r7=0 -> a=0xDEAD_BEEF; repeat with wr_addr=0 -> read of address 0 returns 0.
REQ-035 rsp_ready=0, issue requests a=1, then a=2 -> state TWO, req_ready=0; third request stalls; rsp_ready=1 -> responses 1 then 2 in order, req_ready returns 1.
REQ-036 Hold response for a=3 with rsp_ready=0, then write r3=0x1234_5678 -> rsp_data_a becomes 0x1234_5678 next cycle.
REQ-037 Pulse reset=0 while in TWO -> rsp_valid=0 and outputs 0 immediately; after release req_ready=1, state EMPTY.
